// File: rtl/aira_ml_pkg.sv
// Shared defaults and lane/beat types for the aira_ml input front-end.
// Optional early-frame-end input is enabled with AIRA_ML_PACKER_TLAST_EN.
package aira_ml_pkg;

  localparam int N_DATA_DEF  = 16;
  localparam int N_ADDR_DEF  = 8;
  localparam int N_PORTS_DEF = 4;

  typedef logic [N_DATA_DEF-1:0] lane_data_t;
  typedef logic [N_ADDR_DEF-1:0] lane_addr_t;

  typedef struct packed {
    lane_data_t [N_PORTS_DEF-1:0] data;
    lane_addr_t [N_PORTS_DEF-1:0] addr;
    logic [N_PORTS_DEF-1:0]       lane_en;
  } beat_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aira_ml_beat_reg.sv
// Output holding register: loads a closed beat, holds under stall,
// clears when drained with nothing new behind it.
module aira_ml_beat_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         stall_i,
  input  logic [W-1:0] beat_i,
  output logic [W-1:0] beat_o,
  output logic         valid_o
);

  logic [W-1:0] beat_q, beat_d;
  logic         valid_q, valid_d;

  always_comb begin
    beat_d  = beat_q;
    valid_d = valid_q;
    if (load_i) begin
      beat_d  = beat_i;
      valid_d = 1'b1;
    end else if (valid_q && !stall_i) begin
      beat_d  = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  assign beat_o  = beat_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/aira_ml_port_packer.sv
// Packs a serial element stream into N_PORTS-wide addressed beats.
// Define AIRA_ML_PACKER_TLAST_EN to add the i_last early-frame-end input.
module aira_ml_port_packer
  import aira_ml_pkg::*;
#(
  parameter int N_DATA    = N_DATA_DEF,
  parameter int N_PORTS   = N_PORTS_DEF,
  parameter int N_ADDR    = N_ADDR_DEF,
  parameter int FRAME_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_DATA-1:0] i_data,
  input  logic              i_valid,
`ifdef AIRA_ML_PACKER_TLAST_EN
  input  logic              i_last,
`endif
  output logic              o_ready,
  output logic [N_DATA-1:0] o_data   [N_PORTS-1:0],
  output logic [N_ADDR-1:0] o_d_addr [N_PORTS-1:0],
  output logic [N_PORTS-1:0] o_lane_en,
  output logic              o_d_valid,
  input  logic              i_stall,
  output logic              o_frame_done
);

  localparam int LW = cnt_w(N_PORTS);
  localparam logic [LW-1:0]     LANE_MAX = LW'(N_PORTS - 1);
  localparam logic [N_ADDR-1:0] ELEM_MAX = N_ADDR'(FRAME_LEN - 1);

  typedef struct packed {
    logic [N_PORTS-1:0][N_DATA-1:0] data;
    logic [N_PORTS-1:0][N_ADDR-1:0] addr;
    logic [N_PORTS-1:0]             en;
    logic                           last;
  } pbeat_t;

  localparam int BW = $bits(pbeat_t);

  logic [LW-1:0]     lane_q, lane_d;
  logic [N_ADDR-1:0] elem_q, elem_d;
  pbeat_t            pk_q, pk_d, cur, ld_beat, ob;
  logic              pk_full_q, pk_full_d;
  logic              fd_q;
  logic              d_valid, out_free, acc, fend, close, load, last_w;

`ifdef AIRA_ML_PACKER_TLAST_EN
  assign last_w = i_last;
`else
  assign last_w = 1'b0;
`endif

  always_comb begin
    out_free  = !d_valid || !i_stall;
    o_ready   = !pk_full_q || out_free;
    acc       = i_valid && o_ready;
    fend      = (elem_q == ELEM_MAX) || last_w;
    close     = acc && ((lane_q == LANE_MAX) || fend);
    // A held closed beat never absorbs new elements; they start a fresh beat.
    cur       = pk_full_q ? '0 : pk_q;
    if (acc) begin
      cur.data[lane_q] = i_data;
      cur.addr[lane_q] = elem_q;
      cur.en[lane_q]   = 1'b1;
      cur.last         = fend;
    end
    lane_d    = lane_q;
    elem_d    = elem_q;
    if (acc) begin
      if (fend) begin
        lane_d = '0;
        elem_d = '0;
      end else begin
        elem_d = elem_q + N_ADDR'(1);
        lane_d = (lane_q == LANE_MAX) ? '0 : lane_q + LW'(1);
      end
    end
    pk_d      = pk_q;
    pk_full_d = pk_full_q;
    load      = 1'b0;
    ld_beat   = cur;
    if (pk_full_q) begin
      if (out_free) begin
        load      = 1'b1;
        ld_beat   = pk_q;
        pk_d      = cur;
        pk_full_d = close;
      end
    end else if (close) begin
      if (out_free) begin
        load = 1'b1;
        pk_d = '0;
      end else begin
        pk_d      = cur;
        pk_full_d = 1'b1;
      end
    end else begin
      pk_d = cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q    <= '0;
      elem_q    <= '0;
      pk_q      <= '0;
      pk_full_q <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      elem_q    <= elem_d;
      pk_q      <= pk_d;
      pk_full_q <= pk_full_d;
      fd_q      <= d_valid && !i_stall && ob.last;
    end
  end

  aira_ml_beat_reg #(
    .W(BW)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .stall_i(i_stall),
    .beat_i (ld_beat),
    .beat_o (ob),
    .valid_o(d_valid)
  );

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      o_data[p]   = ob.data[p];
      o_d_addr[p] = ob.addr[p];
    end
    o_lane_en    = ob.en;
    o_d_valid    = d_valid;
    o_frame_done = fd_q;
  end

endmodule
